// File: rtl/aud_dsp_if.sv
// Sample bus between the playback DSP, the SRAM read port and the I2S player.
// Signal names are from the DSP's point of view. The master modport is the DSP;
// the slave modport is the SRAM/DAC side.
interface aud_dsp_if;
  logic [19:0] o_sram_addr;  // SRAM read address
  logic [15:0] i_sram_data;  // SRAM read data, valid one cycle after the address
  logic [15:0] o_dac_data;   // signed output sample
  logic        o_valid;      // one-cycle strobe: o_dac_data updated
  logic        o_done;       // one-cycle pulse: end of recording reached

  modport master (
    output o_sram_addr,
    input  i_sram_data,
    output o_dac_data,
    output o_valid,
    output o_done
  );

  modport slave (
    input  o_sram_addr,
    output i_sram_data,
    input  o_dac_data,
    input  o_valid,
    input  o_done
  );
endinterface

// File: rtl/aud_dsp.sv
// aud_dsp: playback sample processor for the voice recorder.
// Emits one sample per DAC LR frame from SRAM. It supports normal, fast (skip) and
// slow (hold or linear interpolation) speeds.
// Build option: define AUD_DSP_LININT_EN to enable linear interpolation for i_slow_1.
// When it is left undefined, there is no multiplier or divider, and i_slow_1 acts as
// a zero-order hold, exactly like i_slow_0.
module aud_dsp (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_daclrck,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  input  logic        i_fast,
  input  logic        i_slow_0,
  input  logic        i_slow_1,
  input  logic [2:0]  i_speed,
  input  logic [19:0] i_end_addr,
  aud_dsp_if.master   io_bus,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StFetch = 3'd2,
    StCalc  = 3'd3,
    StPause = 3'd4
  } state_e;

  // State and datapath registers
  state_e      r_state;
  logic        r_lrck_q1;
  logic        r_lrck_q2;
  logic [19:0] r_addr;
  logic [15:0] r_prev;
  logic [15:0] r_cur;
  logic [2:0]  r_k;
  logic        r_end_pend;  // last in-range sample already emitted
  logic [15:0] r_dac;
  logic        r_valid;
  logic        r_done;

  // Next-state values
  state_e      w_state_d;
  logic [19:0] w_addr_d;
  logic [15:0] w_prev_d;
  logic [15:0] w_cur_d;
  logic [2:0]  w_k_d;
  logic        w_end_pend_d;
  logic [15:0] w_dac_d;
  logic        w_valid_d;
  logic        w_done_d;

  // Decoded mode and arithmetic
  logic        w_fall;
  logic        w_is_fast;
  logic        w_is_slow;
  logic [3:0]  w_n;
  logic [2:0]  w_k_eff;
  logic        w_advance;
  logic [20:0] w_step;
  logic [20:0] w_next_addr;
  logic        w_past_end;
  logic [15:0] w_out;

  // LR clock edge detector: a frame starts when the registered copy goes 1 -> 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrck_q1 <= 1'b0;
      r_lrck_q2 <= 1'b0;
    end else begin
      r_lrck_q1 <= i_daclrck;
      r_lrck_q2 <= r_lrck_q1;
    end
  end

  assign w_fall = r_lrck_q2 & ~r_lrck_q1;

  // Mode decode. Priority is fast > slow_1 > slow_0 > normal.
  always_comb begin
    w_is_fast = i_fast;
    w_is_slow = ~i_fast & (i_slow_0 | i_slow_1);
    w_n       = {1'b0, i_speed} + 4'd1;
    // If N shrank mid-slow and k is now past its end, treat k as N-1 and advance.
    w_k_eff   = (r_k >= i_speed) ? i_speed : r_k;
    w_advance = ~w_is_slow | (w_k_eff == i_speed);
    // Normal mode steps by 1, as does slow mode when it advances.
    w_step      = w_is_fast ? {17'd0, w_n} : 21'd1;
    // The 21-bit compare keeps the end check correct near the top of the address space.
    w_next_addr = {1'b0, r_addr} + w_step;
    w_past_end  = w_next_addr > {1'b0, i_end_addr};
  end

`ifdef AUD_DSP_LININT_EN
  logic [3:0]         w_wk;
  logic [3:0]         w_wp;
  logic signed [19:0] w_sum;
  logic [15:0]        w_interp;

  // Linear interpolation: (prev*(N-k) + cur*k) / N, truncating toward zero
  always_comb begin
    w_wk     = {1'b0, w_k_eff};
    w_wp     = w_n - w_wk;
    w_sum    = $signed({{4{r_prev[15]}}, r_prev}) * $signed({16'd0, w_wp})
             + $signed({{4{r_cur[15]}}, r_cur}) * $signed({16'd0, w_wk});
    w_interp = 16'(w_sum / $signed({16'd0, w_n}));
  end

  // Output sample select: interpolate for slow_1 only
  always_comb begin
    w_out = (~i_fast & i_slow_1) ? w_interp : r_cur;
  end
`else
  // Output sample select: every mode emits the current sample (hold in slow modes)
  always_comb begin
    w_out = r_cur;
  end
`endif

  // Playback FSM next-state and datapath update
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_prev_d     = r_prev;
    w_cur_d      = r_cur;
    w_k_d        = r_k;
    w_end_pend_d = r_end_pend;
    w_dac_d      = r_dac;
    w_valid_d    = 1'b0;
    w_done_d     = 1'b0;

    if (r_state != StIdle && i_stop) begin
      // Stop wins over pause and start that arrive in the same cycle.
      w_state_d    = StIdle;
      w_addr_d     = 20'd0;
      w_prev_d     = 16'd0;
      w_k_d        = 3'd0;
      w_end_pend_d = 1'b0;
      w_dac_d      = 16'd0;
    end else begin
      case (r_state)
        StIdle: begin
          w_addr_d     = 20'd0;
          w_prev_d     = 16'd0;
          w_k_d        = 3'd0;
          w_end_pend_d = 1'b0;
          w_dac_d      = 16'd0;
          if (i_start) w_state_d = StWait;
        end

        StWait: begin
          if (i_pause) begin
            w_state_d = StPause;
            w_dac_d   = 16'd0;
          end else if (w_fall) begin
            w_state_d = StFetch;
          end
        end

        StFetch: begin
          if (i_pause) begin
            w_state_d = StPause;
            w_dac_d   = 16'd0;
          end else begin
            w_cur_d   = io_bus.i_sram_data;
            w_state_d = StCalc;
          end
        end

        StCalc: begin
          if (i_pause) begin
            // The result of this frame is dropped. Address, k and prev are kept.
            w_state_d = StPause;
            w_dac_d   = 16'd0;
          end else if (r_end_pend) begin
            // The final sample went out on the previous frame, so finish now.
            w_state_d    = StIdle;
            w_done_d     = 1'b1;
            w_addr_d     = 20'd0;
            w_prev_d     = 16'd0;
            w_k_d        = 3'd0;
            w_end_pend_d = 1'b0;
            w_dac_d      = 16'd0;
          end else begin
            w_state_d = StWait;
            w_valid_d = 1'b1;
            w_dac_d   = w_out;
            if (w_advance) begin
              w_k_d    = 3'd0;
              w_prev_d = r_cur;
              // Hold the address rather than wrap; the next frame reports done.
              if (w_past_end) w_end_pend_d = 1'b1;
              else            w_addr_d     = w_next_addr[19:0];
            end else begin
              w_k_d = w_k_eff + 3'd1;
            end
          end
        end

        StPause: begin
          w_dac_d = 16'd0;
          if (i_start) w_state_d = StWait;
        end

        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_addr     <= 20'd0;
      r_prev     <= 16'd0;
      r_cur      <= 16'd0;
      r_k        <= 3'd0;
      r_end_pend <= 1'b0;
      r_dac      <= 16'd0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_prev     <= w_prev_d;
      r_cur      <= w_cur_d;
      r_k        <= w_k_d;
      r_end_pend <= w_end_pend_d;
      r_dac      <= w_dac_d;
      r_valid    <= w_valid_d;
      r_done     <= w_done_d;
    end
  end

  assign io_bus.o_sram_addr = r_addr;
  assign io_bus.o_dac_data  = r_dac;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_done      = r_done;
  assign o_state            = r_state;

endmodule

// File: doc/aud_dsp.md
# aud_dsp

Playback-side sample processor for the lab3 voice recorder. Reads 16-bit left-channel samples written to SRAM by the record path and produces one output sample per DAC LR-clock frame, applying speed control: fast (skip samples), slow with zero-order hold, or slow with linear interpolation. The output sample and strobe feed the I2S player that serializes to the WM8731 DAC.

## Interface
Parameters:
- none

Ports (all synchronous to i_clk, the codec BCLK):
- i_clk  in  1  codec bit clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_daclrck  in  1  DAC LR clock; 0 = left frame
- i_start  in  1  pulse: start from address 0 (in IDLE) or resume (in PAUSE)
- i_pause  in  1  pulse: pause playback
- i_stop  in  1  pulse: abort to IDLE
- i_fast  in  1  fast mode enable
- i_slow_0  in  1  slow mode, zero-order hold
- i_slow_1  in  1  slow mode, linear interpolation
- i_speed  in  3  speed factor N = i_speed + 1 (1..8)
- i_end_addr  in  20  last valid recorded address
- i_sram_data  in  16  SRAM read data, valid 1 cycle after o_sram_addr changes
- o_sram_addr  out  20  SRAM read address
- o_dac_data  out  16  signed output sample
- o_valid  out  1  1-cycle strobe: o_dac_data updated
- o_done  out  1  1-cycle pulse: end of recording reached
- o_state  out  3  current state code

## Operation
- States: IDLE=0, WAIT=1, FETCH=2, CALC=3, PAUSE=4.
- IDLE: o_sram_addr=0, prev=0, k=0, o_dac_data=0. i_start -> WAIT.
- WAIT: a frame begins when a registered copy of i_daclrck shows 1 then 0 (falling edge). On that edge -> FETCH.
- FETCH: hold 1 cycle for SRAM read; latch cur = i_sram_data -> CALC.
- CALC: compute output, assert o_valid, update address/counters -> WAIT, or -> IDLE with o_done if finished.
- Mode priority: i_fast > i_slow_1 > i_slow_0 > normal. Normal: N treated as 1.
- Fast: out = cur; addr += N.
- Slow (either): k counts 0..N-1 per address. Out computed, then k++; at k = N-1, k <= 0, prev <= cur, addr += 1.
- Slow_0 out = prev if k != 0 else cur… no: out = cur for all k (hold).
- Slow_1 out = (prev*(N-k) + cur*k) / N. Operands sign-extended to 20 bits, k and N-k as 4-bit unsigned; 20-bit signed sum; signed divide truncates toward zero; result taken as [15:0] (always in range). prev = 0 at address 0.
- Normal/fast also update prev <= cur each CALC.
- End: if the computed next address > i_end_addr (unsigned, 21-bit compare to avoid wrap), go to IDLE, pulse o_done, addr <= 0. Address never wraps.
- i_pause in WAIT/FETCH/CALC -> PAUSE (current CALC result discarded, no o_valid); addr, k, prev retained; o_dac_data <= 0 (silence). i_start in PAUSE -> WAIT.
- i_stop in any non-IDLE state -> IDLE next cycle; overrides i_pause and i_start in same cycle.
- Mode/speed inputs sampled only in CALC; changing N mid-slow: if k >= new N-1, treat as k = N-1 (advance).

## Timing
- Reset values: o_sram_addr=0, o_dac_data=0, o_valid=0, o_done=0, o_state=0.
- Latency: daclrck falling edge detected at cycle t (register sample), FETCH t+1, CALC t+2, o_dac_data/o_valid registered visible t+3.
- Exactly one o_valid per LR frame during playback; none in IDLE/PAUSE.
- o_done and final o_valid are never in the same cycle; the last in-range sample is output first, done on the next frame's CALC.
- Reset mid-operation: all registers to reset values asynchronously.

## Configuration
- AUD_DSP_LININT_EN defined: i_slow_1 selects linear interpolation as above (divider instantiated).
- Not defined: no multiplier/divider; i_slow_1 behaves identically to i_slow_0 (hold).

## Test plan
- Normal: SRAM[a]=a*100, i_end_addr=4, start -> o_valid outputs 0,100,200,300,400 on successive frames, then o_done, state 0.
- Fast N=3 (i_speed=2), end=7 -> outputs SRAM[0],[3],[6], then o_done.
- Slow_1 N=4, SRAM[0]=400,[1]=800 (macro on) -> outputs 0,100,200,300,400,500,600,700; negative case prev=-7,cur=0,N=2,k=1 -> -3.
- Slow_0 N=2 (or slow_1 with macro off) -> each sample emitted twice: 0,0,100,100,...
- Pause after 2 samples, 3 frames idle with o_dac_data=0 and no o_valid, start -> resumes at address 2.
- i_stop mid-FETCH -> IDLE next cycle, addr 0, no o_valid; async reset in CALC -> all outputs 0 immediately.
